// File: rtl/c2c_r_arbiter.sv
// Round-robin arbiter for two read requesters on one c2c_r bus. A request seen in IDLE reaches the bus one cycle later.
// Acks are combinational with mem_ack. Requesters wait by holding re, and a memory transaction is never aborted.
module c2c_r_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_re,
  input  logic [XLEN/8-1:0] i_sel,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_ack,
  output logic [XLEN-1:0]   i_data,
  input  logic              d_re,
  input  logic [XLEN/8-1:0] d_sel,
  input  logic [XLEN-1:0]   d_addr,
  output logic              d_ack,
  output logic [XLEN-1:0]   d_data,
  output logic              mem_re,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_data
);

  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;     // most recent grant went to port D
  logic            discard_q, discard_d;
  logic            mem_re_q, mem_re_d;
  logic [SW-1:0]   mem_sel_q, mem_sel_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            grant_req;
  logic            grant_to_d;

  assign i_data   = mem_data;
  assign d_data   = mem_data;
  assign mem_re   = mem_re_q;
  assign mem_sel  = mem_sel_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    discard_d  = discard_q;
    mem_re_d   = mem_re_q;
    mem_sel_d  = mem_sel_q;
    mem_addr_d = mem_addr_q;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    grant_req  = 1'b0;
    grant_to_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_re || d_re) begin
          grant_req  = 1'b1;
          grant_to_d = d_re && (!i_re || !last_d_q);
        end
      end
      ST_BUSY_I: begin
        if (mem_ack) begin
          i_ack     = !discard_q;
          discard_d = 1'b0;
          // The acked owner's re is still high here, so only the other port can take over.
          if (d_re) begin
            grant_req  = 1'b1;
            grant_to_d = 1'b1;
          end else begin
            mem_re_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end else if (!i_re) begin
          discard_d = 1'b1;
        end
      end
      ST_BUSY_D: begin
        if (mem_ack) begin
          d_ack     = !discard_q;
          discard_d = 1'b0;
          if (i_re) begin
            grant_req  = 1'b1;
            grant_to_d = 1'b0;
          end else begin
            mem_re_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end else if (!d_re) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_re_d = 1'b0;
      end
    endcase

    if (grant_req) begin
      mem_re_d   = 1'b1;
      last_d_d   = grant_to_d;
      discard_d  = 1'b0;
      state_d    = grant_to_d ? ST_BUSY_D : ST_BUSY_I;
      mem_addr_d = grant_to_d ? d_addr : i_addr;
      mem_sel_d  = grant_to_d ? d_sel : i_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      last_d_q   <= 1'b0;
      discard_q  <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_sel_q  <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      discard_q  <= discard_d;
      mem_re_q   <= mem_re_d;
      mem_sel_q  <= mem_sel_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_c2c_r_arbiter.sv
// Bench for c2c_r_arbiter: directed scenarios plus random traffic, checked each cycle against a transaction-level model.
module tb_c2c_r_arbiter;
  localparam int XLEN = 32;
  localparam int SW   = XLEN / 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            i_re = 1'b0, d_re = 1'b0, mem_ack = 1'b0;
  logic [SW-1:0]   i_sel = '0, d_sel = '0;
  logic [XLEN-1:0] i_addr = '0, d_addr = '0, mem_data = '0;
  logic            i_ack, d_ack, mem_re;
  logic [XLEN-1:0] i_data, d_data, mem_addr;
  logic [SW-1:0]   mem_sel;

  always #5 clk = ~clk;

  c2c_r_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_re(i_re), .i_sel(i_sel), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_re(d_re), .d_sel(d_sel), .d_addr(d_addr), .d_ack(d_ack), .d_data(d_data),
    .mem_re(mem_re), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: at most one memory transaction in flight, described by who owns it,
  // what address/sel it carries, and whether its owner abandoned it.
  bit              t_live;
  bit              t_port_d;
  bit              t_dead;
  bit              prefer_i;     // on a tie, I wins only if D was served last
  logic [XLEN-1:0] bus_addr;
  logic [SW-1:0]   bus_sel;

  typedef struct {
    bit              port_d;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } ack_t;
  ack_t ack_log[$];

  bit              exp_iack, exp_dack;
  logic            obs_re;
  logic [XLEN-1:0] obs_addr;

  function automatic void model_reset();
    t_live = 0; t_port_d = 0; t_dead = 0; prefer_i = 0;
    bus_addr = '0; bus_sel = '0;
  endfunction

  function automatic void start_txn(input bit to_d, input logic [XLEN-1:0] ia, input logic [XLEN-1:0] da,
                                    input logic [SW-1:0] is, input logic [SW-1:0] ds);
    t_live   = 1;
    t_dead   = 0;
    t_port_d = to_d;
    prefer_i = to_d;
    bus_addr = to_d ? da : ia;
    bus_sel  = to_d ? ds : is;
  endfunction

  task automatic step(input bit ire, input bit dre, input logic [XLEN-1:0] ia, input logic [XLEN-1:0] da,
                      input logic [SW-1:0] is, input logic [SW-1:0] ds, input bit mack, input logic [XLEN-1:0] md);
    bit owner_re, other_re;
    @(negedge clk);
    i_re = ire; d_re = dre; i_addr = ia; d_addr = da; i_sel = is; d_sel = ds;
    mem_ack = mack; mem_data = md;
    #1;
    exp_iack = t_live && mack && !t_port_d && !t_dead;
    exp_dack = t_live && mack &&  t_port_d && !t_dead;
    chk("mem_re",   mem_re,   t_live);
    chk("mem_addr", mem_addr, bus_addr);
    chk("mem_sel",  mem_sel,  bus_sel);
    chk("i_ack",    i_ack,    exp_iack);
    chk("d_ack",    d_ack,    exp_dack);
    chk("i_data",   i_data,   md);
    chk("d_data",   d_data,   md);
    obs_re   = mem_re;
    obs_addr = mem_addr;
    if (i_ack) ack_log.push_back('{0, mem_addr, i_data});
    if (d_ack) ack_log.push_back('{1, mem_addr, d_data});
    owner_re = t_port_d ? dre : ire;
    other_re = t_port_d ? ire : dre;
    if (t_live) begin
      if (mack) begin
        if (other_re) start_txn(!t_port_d, ia, da, is, ds);
        else t_live = 0;
        t_dead = 0;
      end else if (!owner_re) begin
        t_dead = 1;
      end
    end else if (ire || dre) begin
      start_txn(dre && (!ire || !prefer_i), ia, da, is, ds);
    end
  endtask

  task automatic idle_step(input bit mack);
    step(0, 0, '0, '0, '0, '0, mack, XLEN'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; i_re = 0; d_re = 0; mem_ack = 1;
    #1;
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_sel", mem_sel, '0);
    chk("rst_acks", {i_ack, d_ack}, 2'b00);
    model_reset();
    @(negedge clk);
    reset_n = 1; mem_ack = 0;
    ack_log.delete();
  endtask

  bit              r_ire, r_dre, r_mack;
  logic [XLEN-1:0] r_ia, r_da;
  logic [SW-1:0]   r_is, r_ds;
  int              bubbles;

  initial begin
    model_reset();
    do_reset();

    // Single I read with mem_ack three cycles after mem_re rises.
    step(1, 0, 32'h100, '0, 4'hF, '0, 0, '0);
    chk("single_addr_next", obs_addr, 32'h0);
    step(1, 0, 32'h100, '0, 4'hF, '0, 0, '0);
    chk("single_bus_addr", obs_addr, 32'h100);
    step(1, 0, 32'h100, '0, 4'hF, '0, 0, '0);
    step(1, 0, 32'h100, '0, 4'hF, '0, 0, '0);
    step(1, 0, 32'h100, '0, 4'hF, '0, 1, 32'hDEADBEEF);
    idle_step(0);
    chk("single_nacks", ack_log.size(), 1);
    if (ack_log.size() == 1) begin
      chk("single_port", ack_log[0].port_d, 1'b0);
      chk("single_data", ack_log[0].data, 32'hDEADBEEF);
    end

    // Both requesters from reset, holding re for six back-to-back transactions.
    do_reset();
    bubbles = 0;
    step(1, 1, 32'h10, 32'h20, 4'h3, 4'hC, 0, '0);
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 32'h10, 32'h20, 4'h3, 4'hC, 0, '0);
      if (!obs_re) bubbles++;
      step(1, 1, 32'h10, 32'h20, 4'h3, 4'hC, 1, 32'hA000 + k);
      if (!obs_re) bubbles++;
    end
    idle_step(0);
    idle_step(0);
    chk("rr_bubbles", bubbles, 0);
    chk("rr_nacks", ack_log.size(), 6);
    for (int k = 0; k < 6 && k < ack_log.size(); k++) begin
      chk("rr_port", ack_log[k].port_d, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_addr", ack_log[k].addr, (k % 2 == 0) ? 32'h20 : 32'h10);
    end

    // I flushes one cycle into its transaction, then asks for 0x200.
    do_reset();
    step(1, 0, 32'h180, '0, 4'hF, '0, 0, '0);
    step(1, 0, 32'h180, '0, 4'hF, '0, 0, '0);
    step(0, 0, 32'h180, '0, 4'hF, '0, 0, '0);
    step(1, 0, 32'h200, '0, 4'h1, '0, 0, '0);
    step(1, 0, 32'h200, '0, 4'h1, '0, 1, 32'h0BAD0BAD);
    step(1, 0, 32'h200, '0, 4'h1, '0, 0, '0);
    step(1, 0, 32'h200, '0, 4'h1, '0, 0, '0);
    chk("flush_new_addr", obs_addr, 32'h200);
    step(1, 0, 32'h200, '0, 4'h1, '0, 1, 32'h12345678);
    idle_step(0);
    chk("flush_nacks", ack_log.size(), 1);
    if (ack_log.size() == 1) chk("flush_data", ack_log[0].data, 32'h12345678);

    // Asynchronous reset while D is in flight; the late mem_ack must be ignored.
    do_reset();
    step(0, 1, '0, 32'h300, '0, 4'h6, 0, '0);
    step(0, 1, '0, 32'h300, '0, 4'h6, 0, '0);
    chk("busy_before_rst", obs_re, 1'b1);
    @(negedge clk);
    #2 reset_n = 0;
    #1 chk("async_drop", mem_re, 1'b0);
    model_reset();
    d_re = 0;
    @(negedge clk);
    reset_n = 1;
    ack_log.delete();
    idle_step(1);
    idle_step(0);
    chk("rst_late_ack", ack_log.size(), 0);

    // Stray mem_ack in IDLE, then D moves its address mid-transaction.
    idle_step(1);
    step(0, 1, '0, 32'h400, '0, 4'h2, 0, '0);
    step(0, 1, '0, 32'h500, '0, 4'h8, 0, '0);
    chk("addr_held", obs_addr, 32'h400);
    step(0, 1, '0, 32'h500, '0, 4'h8, 1, 32'h55AA55AA);
    idle_step(0);
    chk("held_nacks", ack_log.size(), 1);
    if (ack_log.size() == 1) chk("held_ack_addr", ack_log[0].addr, 32'h400);

    // Random traffic with withdrawals, address wiggles and stray acks.
    do_reset();
    r_ire = 0; r_dre = 0; r_ia = '0; r_da = '0; r_is = '0; r_ds = '0;
    for (int c = 0; c < 4000; c++) begin
      r_mack = t_live ? ($urandom_range(2, 0) == 0) : ($urandom_range(9, 0) == 0);
      step(r_ire, r_dre, r_ia, r_da, r_is, r_ds, r_mack, XLEN'($urandom));
      if (r_ire) begin
        if (exp_iack) r_ire = $urandom_range(1, 0) == 1;
        else if ($urandom_range(19, 0) == 0) r_ire = 0;
        if (exp_iack || $urandom_range(14, 0) == 0) begin
          r_ia = XLEN'($urandom); r_is = SW'($urandom);
        end
      end else if ($urandom_range(2, 0) == 0) begin
        r_ire = 1; r_ia = XLEN'($urandom); r_is = SW'($urandom);
      end
      if (r_dre) begin
        if (exp_dack) r_dre = $urandom_range(1, 0) == 1;
        else if ($urandom_range(19, 0) == 0) r_dre = 0;
        if (exp_dack || $urandom_range(14, 0) == 0) begin
          r_da = XLEN'($urandom); r_ds = SW'($urandom);
        end
      end else if ($urandom_range(2, 0) == 0) begin
        r_dre = 1; r_da = XLEN'($urandom); r_ds = SW'($urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
